// File: rtl/uart_receiver.sv
// 8N1 UART receive path with mid-bit sampling, framing and overrun detection.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at each sample point.
module uart_receiver #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int BIT_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF     = BIT_TIME / 2;
  localparam logic [15:0] BIT_END  = 16'(BIT_TIME - 1);
  localparam logic [15:0] HALF_END = 16'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_meta_q, rx_sync_q;
  logic        rx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_h1_q, rx_h2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_h1_q <= 1'b1;
      rx_h2_q <= 1'b1;
    end else begin
      rx_h1_q <= rx_sync_q;
      rx_h2_q <= rx_h1_q;
    end
  end

  // votes over the sync output at counts N-2, N-1 and N
  assign rx_bit = (rx_sync_q & rx_h1_q) |
                  (rx_sync_q & rx_h2_q) |
                  (rx_h1_q & rx_h2_q);
`else
  assign rx_bit = rx_sync_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (!rx_sync_q) state_d = START;
      START:
        if (cnt_q == HALF_END)
          state_d = rx_bit ? IDLE : DATA;
      DATA:
        if (cnt_q == BIT_END && idx_q == 3'd7)
          state_d = STOP;
      STOP:
        if (cnt_q == BIT_END)
          state_d = rx_bit ? IDLE : WAIT_IDLE;
      WAIT_IDLE:
        if (rx_sync_q) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  logic bit_tick, stop_tick, complete, accept;

  always_comb begin
    bit_tick  = (state_q == DATA) && (cnt_q == BIT_END);
    stop_tick = (state_q == STOP) && (cnt_q == BIT_END);
    complete  = stop_tick && rx_bit;
    accept    = valid_q && i_data_ready;

    // count restarts on each state entry and at every data bit
    if (state_d != state_q || bit_tick) cnt_d = 16'd0;
    else                                cnt_d = cnt_q + 16'd1;

    idx_d   = idx_q;
    shift_d = shift_q;
    if (state_q == START && state_d == DATA) idx_d = 3'd0;
    if (bit_tick) begin
      idx_d   = idx_q + 3'd1;
      shift_d = {rx_bit, shift_q[7:1]};
    end

    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (complete) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end

    ferr_d = stop_tick && !rx_bit;
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at BIT_TIME = 10.
// Expected bytes are queued by stimulus and popped by the output monitor.
module tb_uart_receiver;

  localparam int BT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_overrun;

  uart_receiver #(
    .BAUD_RATE (100000),
    .CLOCK_FREQ(1000000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .i_data_ready(ready),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  int e_cyc = 0;
  int rise_cyc = -1;
  int err_cycles = 0;
  int ovr_cycles = 0;
  logic pv = 1'b0;
  logic pacc = 1'b0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // a byte is newly presented on a valid rise or a same-cycle reload
  always @(negedge clk) begin
    if (o_frame_err) err_cycles++;
    if (o_overrun) ovr_cycles++;
    if (rst) begin
      pv = 1'b0;
      pacc = 1'b0;
    end else begin
      if (o_data_valid && (!pv || pacc)) begin
        if (!pv) rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_byte: got 0x%02h, expected none",
                   o_data);
        end else begin
          check("rx_byte", int'(o_data), int'(exp_q.pop_front()));
        end
      end
      pacc = o_data_valid && ready;
      pv = o_data_valid;
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept();
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
  endtask

  task automatic send_frame(logic [7:0] b, logic stop_bit, int glitch);
    e_cyc = cyc + 1;
    rx = 1'b0;
    idle(BT);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == glitch) begin
        idle(5);
        rx = 1'b1;
        idle(1);
        rx = b[k];
        idle(4);
      end else begin
        idle(BT);
      end
    end
    rx = stop_bit;
    idle(BT);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int err0;
  int ovr0;

  initial begin
    idle(3);
    check("rst_data", int'(o_data), 0);
    check("rst_valid", int'(o_data_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    check("rst_ovr", int'(o_overrun), 0);
    rst = 1'b0;
    idle(20);

    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    idle(5);
    check("valid_latency", rise_cyc - e_cyc, 97);
    check("valid_hold", int'(o_data_valid), 1);
    check("data_a5", int'(o_data), 'hA5);
    accept();
    check("valid_clear", int'(o_data_valid), 0);
    check("data_keep", int'(o_data), 'hA5);

    err0 = err_cycles;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(1);
    check("busy_glitch", int'(o_busy), 1);
    idle(20);
    check("busy_idle", int'(o_busy), 0);
    check("glitch_noerr", err_cycles - err0, 0);
    check("glitch_novalid", int'(o_data_valid), 0);

    err0 = err_cycles;
    send_frame(8'h3C, 1'b0, -1);
    idle(30 * BT);
    rx = 1'b1;
    idle(20);
    check("break_err_once", err_cycles - err0, 1);
    check("break_novalid", int'(o_data_valid), 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    idle(5);
    check("after_break_valid", int'(o_data_valid), 1);
    accept();

    ovr0 = ovr_cycles;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(5);
    check("overrun_once", ovr_cycles - ovr0, 1);
    check("overrun_keep", int'(o_data), 'h11);
    accept();

    ovr0 = ovr_cycles;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1);
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        repeat (97) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    idle(5);
    check("reload_noovr", ovr_cycles - ovr0, 0);
    check("reload_data", int'(o_data), 'h22);
    check("reload_valid", int'(o_data_valid), 1);
    accept();

    rx = 1'b0;
    idle(BT);
    rx = 1'b1;
    idle(4 * BT + 5);
    check("busy_mid_frame", int'(o_busy), 1);
    rst = 1'b1;
    #1;
    check("arst_data", int'(o_data), 0);
    check("arst_valid", int'(o_data_valid), 0);
    check("arst_busy", int'(o_busy), 0);
    idle(3);
    rst = 1'b0;
    idle(BT + 40);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    idle(5);
    check("post_rst_valid", int'(o_data_valid), 1);
    accept();

`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h04);
`endif
    send_frame(8'h00, 1'b1, 2);
    idle(5);
    check("glitch_frame_valid", int'(o_data_valid), 1);
    accept();
    idle(5);

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
